// File: rtl/uart_disp_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_disp_cmd_ctrl
//
// Parses framed commands arriving from a UART byte receiver and updates the
// 7-segment display configuration (digits, decimal points, blank) atomically,
// one frame at a time. Malformed, unknown or stalled frames are rejected and
// reported through a sticky error code plus a one-cycle cmd_err pulse.
//
// Frame: SYNC, CMD, ARG0, ARG1[, CHK]   with CHK = CMD ^ ARG0 ^ ARG1
// Optional feature macro: UART_DISP_CMD_CHECKSUM_EN
//   defined     -> 5-byte frames, checksum verified (err_code 1 on mismatch)
//   not defined -> 4-byte frames, ARG1 goes straight to EXEC
//
// Parameters:
//   TIMEOUT_CYCLES  longest idle gap between bytes inside a frame
//   SYNC_BYTE       frame start marker
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_data         received byte, stable once rx_toggle has changed
//   rx_toggle       inverts once per received byte (clk domain)
//   digits          {d3,d2,d1,d0}, 4 bits each
//   dp_mask         decimal point enables, bit i = digit i
//   blank           1 = display off
//   busy            frame in progress
//   cmd_ok/cmd_err  one-cycle result pulses
//   err_code        last result: 0 ok, 1 checksum, 2 unknown cmd, 3 timeout
// -----------------------------------------------------------------------------
module uart_disp_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 208320,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_toggle,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic        blank,
    output logic        busy,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [1:0]  err_code
);

    localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_CMD = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] OP_DIGITS = 8'h01;
    localparam logic [7:0] OP_DP     = 8'h02;
    localparam logic [7:0] OP_BLANK  = 8'h03;
    localparam logic [7:0] OP_CLEAR  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ARG0 = 3'd2,
        S_ARG1 = 3'd3,
`ifdef UART_DISP_CMD_CHECKSUM_EN
        S_CHK  = 3'd4,
`endif
        S_EXEC = 3'd5
    } state_t;

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic            tog_q;
    logic            byte_evt_s;
    logic            waiting_s;
    logic            tmo_s;
    logic            chk_ok_s;
    logic [7:0]      cmd_r, arg0_r, arg1_r;
    logic [15:0]     digits_r, digits_n;
    logic [3:0]      dp_mask_r, dp_n;
    logic            blank_r, blank_n;
    logic            busy_r;
    logic            cmd_ok_r, ok_s;
    logic            cmd_err_r, err_s;
    logic [1:0]      err_code_r, code_n;

    assign byte_evt_s = rx_toggle ^ tog_q;

`ifdef UART_DISP_CMD_CHECKSUM_EN
    logic [7:0] chk_r;

    function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                             input logic [7:0] a0,
                                             input logic [7:0] a1);
        return c ^ a0 ^ a1;
    endfunction

    assign chk_ok_s = (chk_r == frame_chk(cmd_r, arg0_r, arg1_r));
`else
    assign chk_ok_s = 1'b1;
`endif

    // Capture each frame byte into its register in the state that expects it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r  <= 8'h00;
            arg0_r <= 8'h00;
            arg1_r <= 8'h00;
`ifdef UART_DISP_CMD_CHECKSUM_EN
            chk_r  <= 8'h00;
`endif
        end else if (byte_evt_s) begin
            case (state_r)
                S_CMD:  cmd_r  <= rx_data;
                S_ARG0: arg0_r <= rx_data;
                S_ARG1: arg1_r <= rx_data;
`ifdef UART_DISP_CMD_CHECKSUM_EN
                S_CHK:  chk_r  <= rx_data;
`endif
                default: ;
            endcase
        end
    end

    // Next-state, gap counter, command execution and result decode
    always_comb begin
        state_n  = state_r;
        cnt_n    = '0;
        ok_s     = 1'b0;
        err_s    = 1'b0;
        code_n   = err_code_r;
        digits_n = digits_r;
        dp_n     = dp_mask_r;
        blank_n  = blank_r;
        waiting_s = (state_r == S_CMD) || (state_r == S_ARG0) ||
`ifdef UART_DISP_CMD_CHECKSUM_EN
                    (state_r == S_CHK) ||
`endif
                    (state_r == S_ARG1);
        // A byte arriving on the expiry cycle wins over the timeout
        tmo_s = waiting_s && !byte_evt_s && (cnt_r == TO_LAST);

        case (state_r)
            S_IDLE: begin
                if (byte_evt_s && (rx_data == SYNC_BYTE)) state_n = S_CMD;
                else                                      state_n = S_IDLE;
            end
            S_CMD: begin
                if (byte_evt_s)  state_n = S_ARG0;
                else if (tmo_s)  state_n = S_IDLE;
                else             state_n = S_CMD;
            end
            S_ARG0: begin
                if (byte_evt_s)  state_n = S_ARG1;
                else if (tmo_s)  state_n = S_IDLE;
                else             state_n = S_ARG0;
            end
            S_ARG1: begin
`ifdef UART_DISP_CMD_CHECKSUM_EN
                if (byte_evt_s)  state_n = S_CHK;
`else
                if (byte_evt_s)  state_n = S_EXEC;
`endif
                else if (tmo_s)  state_n = S_IDLE;
                else             state_n = S_ARG1;
            end
`ifdef UART_DISP_CMD_CHECKSUM_EN
            S_CHK: begin
                if (byte_evt_s)  state_n = S_EXEC;
                else if (tmo_s)  state_n = S_IDLE;
                else             state_n = S_CHK;
            end
`endif
            S_EXEC: begin
                // Single-cycle state; any byte arriving here is dropped
                state_n = S_IDLE;
                if (!chk_ok_s) begin
                    err_s  = 1'b1;
                    code_n = ERR_CHK;
                end else begin
                    ok_s   = 1'b1;
                    code_n = ERR_OK;
                    case (cmd_r)
                        OP_DIGITS: digits_n = {arg1_r, arg0_r};
                        OP_DP:     dp_n     = arg0_r[3:0];
                        OP_BLANK:  blank_n  = arg0_r[0];
                        OP_CLEAR: begin
                            digits_n = 16'h0000;
                            dp_n     = 4'h0;
                            blank_n  = 1'b0;
                        end
                        default: begin
                            ok_s   = 1'b0;
                            err_s  = 1'b1;
                            code_n = ERR_CMD;
                        end
                    endcase
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (tmo_s) begin
            err_s  = 1'b1;
            code_n = ERR_TMO;
        end else if (waiting_s && !byte_evt_s) begin
            cnt_n = cnt_r + CNT_ONE;
        end else begin
            cnt_n = '0;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            tog_q      <= 1'b0;
            digits_r   <= 16'h0000;
            dp_mask_r  <= 4'h0;
            blank_r    <= 1'b0;
            busy_r     <= 1'b0;
            cmd_ok_r   <= 1'b0;
            cmd_err_r  <= 1'b0;
            err_code_r <= 2'd0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            tog_q      <= rx_toggle;
            digits_r   <= digits_n;
            dp_mask_r  <= dp_n;
            blank_r    <= blank_n;
            busy_r     <= (state_n != S_IDLE);
            cmd_ok_r   <= ok_s;
            cmd_err_r  <= err_s;
            err_code_r <= code_n;
        end
    end

    assign digits   = digits_r;
    assign dp_mask  = dp_mask_r;
    assign blank    = blank_r;
    assign busy     = busy_r;
    assign cmd_ok   = cmd_ok_r;
    assign cmd_err  = cmd_err_r;
    assign err_code = err_code_r;

endmodule
